// File: rtl/dram_arb_if.sv
// Requester/sequencer-facing signal bundle for the DRAM arbiter.
// The arbiter uses the slave modport; the CPU/DMA/sequencer side uses master.
interface dram_arb_if;
    logic       cpu_req;
    logic       dma_req;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic       seq_start;
    logic [1:0] seq_kind;
    logic       seq_done;
    logic [2:0] refresh_pending;
    logic       refresh_ovf;

    modport master (
        output cpu_req, dma_req, seq_done,
        input  cpu_gnt, dma_gnt, seq_start, seq_kind, refresh_pending, refresh_ovf
    );

    modport slave (
        input  cpu_req, dma_req, seq_done,
        output cpu_gnt, dma_gnt, seq_start, seq_kind, refresh_pending, refresh_ovf
    );
endinterface

// File: rtl/dram_arb.sv
// DRAM sequencer arbiter: CPU/DMA round robin plus CBR refresh bookkeeping
// with an urgency threshold that lets owed refreshes pre-empt the requesters.
module dram_arb #(
    parameter int REFRESH_CNT = 375,
    parameter int URGENT_LVL  = 2
) (
    input  logic        clk,
    input  logic        rst,
    dram_arb_if.slave   bus
);
    localparam int TW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {K_CPU = 2'b00, K_DMA = 2'b01, K_REF = 2'b10} kind_t;

    state_t        state, state_nx;
    kind_t         kind, kind_nx;
    logic          cpu_gnt, cpu_gnt_nx;
    logic          dma_gnt, dma_gnt_nx;
    logic          seq_start, start_nx;
    logic          last_dma, last_dma_nx;
    logic [TW-1:0] timer;
    logic [2:0]    pending;
    logic          ovf;
    logic          tick, issue, urgent;
    logic          win_ref, win_cpu, win_dma;

    assign tick   = (timer == TW'(REFRESH_CNT - 1));
    assign urgent = (int'(pending) >= URGENT_LVL);

    // Low-priority refresh only fills otherwise idle sequencer slots.
    assign win_ref = urgent || (pending != 3'd0 && !bus.cpu_req && !bus.dma_req);
    assign win_cpu = !urgent && bus.cpu_req && (!bus.dma_req || last_dma);
    assign win_dma = !urgent && bus.dma_req && (!bus.cpu_req || !last_dma);
    assign issue   = (state == IDLE) && win_ref;

    always_comb begin
        state_nx    = state;
        kind_nx     = kind;
        cpu_gnt_nx  = cpu_gnt;
        dma_gnt_nx  = dma_gnt;
        start_nx    = 1'b0;
        last_dma_nx = last_dma;
        case (state)
            IDLE: begin
                if (win_ref) begin
                    state_nx = BUSY;
                    kind_nx  = K_REF;
                    start_nx = 1'b1;
                end else if (win_cpu) begin
                    state_nx    = BUSY;
                    kind_nx     = K_CPU;
                    start_nx    = 1'b1;
                    cpu_gnt_nx  = 1'b1;
                    last_dma_nx = 1'b0;
                end else if (win_dma) begin
                    state_nx    = BUSY;
                    kind_nx     = K_DMA;
                    start_nx    = 1'b1;
                    dma_gnt_nx  = 1'b1;
                    last_dma_nx = 1'b1;
                end
            end
            BUSY: begin
                if (bus.seq_done) begin
                    state_nx   = IDLE;
                    cpu_gnt_nx = 1'b0;
                    dma_gnt_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kind      <= K_CPU;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            seq_start <= 1'b0;
            last_dma  <= 1'b1;
        end else begin
            state     <= state_nx;
            kind      <= kind_nx;
            cpu_gnt   <= cpu_gnt_nx;
            dma_gnt   <= dma_gnt_nx;
            seq_start <= start_nx;
            last_dma  <= last_dma_nx;
        end
    end

    // Refresh timer and owed-refresh counter keep running through BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            pending <= 3'd0;
            ovf     <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + TW'(1);
            if (tick && !issue) begin
                if (pending == 3'd7) ovf <= 1'b1;
                else                 pending <= pending + 3'd1;
            end else if (issue && !tick) begin
                pending <= pending - 3'd1;
            end
        end
    end

    assign bus.cpu_gnt         = cpu_gnt;
    assign bus.dma_gnt         = dma_gnt;
    assign bus.seq_start       = seq_start;
    assign bus.seq_kind        = kind;
    assign bus.refresh_pending = pending;
    assign bus.refresh_ovf     = ovf;
endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb with a short refresh period: a per-clock
// vector table for the main arbitration trace, then hand-written corner cases.
module tb_dram_arb;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    dram_arb_if bus ();

    dram_arb #(.REFRESH_CNT(8), .URGENT_LVL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pack: {cpu_gnt, dma_gnt, seq_start, seq_kind[1:0], pending[2:0]}
    typedef struct {
        logic       cpu;
        logic       dma;
        logic       done;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] pk(input logic cg, input logic dg, input logic st,
                                      input logic [1:0] k, input logic [2:0] p);
        return {cg, dg, st, k, p};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.cpu_gnt, bus.dma_gnt, bus.seq_start, bus.seq_kind, bus.refresh_pending};
    endfunction

    task automatic add(input logic c, input logic d, input logic dn, input logic [7:0] e);
        vec_t v;
        v.cpu = c; v.dma = d; v.done = dn; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic c, input logic d, input logic dn);
        bus.cpu_req  = c;
        bus.dma_req  = d;
        bus.seq_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.seq_done = 1'b0;

        // Edge-by-edge trace from reset release: tie round robin, idle refresh,
        // busy across a tick, tick coincident with issue, done ignored in IDLE.
        add(1,1,0, pk(1,0,1,2'b00,3'd0));  // 1  CPU wins first tie
        add(1,1,0, pk(1,0,0,2'b00,3'd0));  // 2
        add(1,1,0, pk(1,0,0,2'b00,3'd0));  // 3
        add(1,1,1, pk(0,0,0,2'b00,3'd0));  // 4  done
        add(1,1,0, pk(0,1,1,2'b01,3'd0));  // 5  DMA
        add(1,1,0, pk(0,1,0,2'b01,3'd0));  // 6
        add(1,1,0, pk(0,1,0,2'b01,3'd0));  // 7
        add(1,1,1, pk(0,0,0,2'b01,3'd1));  // 8  done + tick
        add(1,1,0, pk(1,0,1,2'b00,3'd1));  // 9  CPU beats low refresh
        add(1,1,0, pk(1,0,0,2'b00,3'd1));  // 10
        add(1,1,0, pk(1,0,0,2'b00,3'd1));  // 11
        add(1,1,1, pk(0,0,0,2'b00,3'd1));  // 12
        add(0,0,0, pk(0,0,1,2'b10,3'd0));  // 13 idle refresh
        add(0,0,1, pk(0,0,0,2'b10,3'd0));  // 14
        add(1,0,0, pk(1,0,1,2'b00,3'd0));  // 15
        add(0,0,0, pk(1,0,0,2'b00,3'd1));  // 16 tick in BUSY, gnt held
        add(0,1,0, pk(1,0,0,2'b00,3'd1));  // 17 DMA req ignored in BUSY
        add(0,0,0, pk(1,0,0,2'b00,3'd1));  // 18
        add(0,0,0, pk(1,0,0,2'b00,3'd1));  // 19
        add(0,0,0, pk(1,0,0,2'b00,3'd1));  // 20
        add(0,0,0, pk(1,0,0,2'b00,3'd1));  // 21
        add(0,0,0, pk(1,0,0,2'b00,3'd1));  // 22
        add(0,0,1, pk(0,0,0,2'b00,3'd1));  // 23
        add(0,0,0, pk(0,0,1,2'b10,3'd1));  // 24 tick + issue
        add(0,0,1, pk(0,0,0,2'b10,3'd1));  // 25
        add(0,0,0, pk(0,0,1,2'b10,3'd0));  // 26
        add(0,0,1, pk(0,0,0,2'b10,3'd0));  // 27
        add(0,0,1, pk(0,0,0,2'b10,3'd0));  // 28 done in IDLE ignored

        do_reset();
        chk("reset_outputs", {obs(), bus.refresh_ovf}, {pk(0,0,0,2'b00,3'd0), 1'b0});
        foreach (vecs[i]) begin
            step(vecs[i].cpu, vecs[i].dma, vecs[i].done);
            chk($sformatf("trace_edge%0d", i + 1), obs(), vecs[i].exp);
            chk($sformatf("gnt_excl_edge%0d", i + 1), bus.cpu_gnt & bus.dma_gnt, 0);
        end

        // Stall with CPU held: two owed refreshes become urgent.
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0);
        chk("stall16_pending_gnt", obs(), pk(1,0,0,2'b00,3'd2));
        step(1, 0, 1);
        chk("stall16_done", obs(), pk(0,0,0,2'b00,3'd2));
        step(1, 0, 0);
        chk("urgent_refresh_wins", obs(), pk(0,0,1,2'b10,3'd1));

        // Long stall: saturation and sticky overflow.
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < 64; i++) step(1, 0, 0);
        chk("sat_pending_ovf", {obs(), bus.refresh_ovf}, {pk(1,0,0,2'b00,3'd7), 1'b1});
        step(1, 0, 1);
        chk("sat_after_done", {obs(), bus.refresh_ovf}, {pk(0,0,0,2'b00,3'd7), 1'b1});
        step(1, 0, 0);
        chk("sat_refresh_ovf_sticky", {obs(), bus.refresh_ovf}, {pk(0,0,1,2'b10,3'd6), 1'b1});
        do_reset();
        chk("ovf_cleared_by_reset", {obs(), bus.refresh_ovf}, {pk(0,0,0,2'b00,3'd0), 1'b0});

        // Reset mid-BUSY aborts the DMA grant; a stray done afterwards is ignored.
        step(0, 1, 0);
        chk("dma_grant", obs(), pk(0,1,1,2'b01,3'd0));
        step(0, 1, 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        chk("rst_aborts_dma", obs(), pk(0,0,0,2'b00,3'd0));
        step(0, 0, 1);
        chk("done_after_rst_ignored", obs(), pk(0,0,0,2'b00,3'd0));
        step(0, 1, 0);
        chk("idle_after_rst", obs(), pk(0,1,1,2'b01,3'd0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
